// File: rtl/gpr_pkg.sv
// gpr_pkg: shared constants and types for the general-purpose register file.
//   DATA_W_DEF / ADDR_W_DEF : default register width and index width
//   NUM_REGS                : number of architectural registers (GR0..GR31)
//   GR0_IDX                 : index of the hardwired-zero register
//   reg_idx_t               : register-index type
package gpr_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_REGS   = 32;
    localparam int GR0_IDX    = 0;

    typedef logic [ADDR_W_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/gpr_file_decoder.sv
// binaryDecoder: N-to-2**N one-hot decoder with enable (default 5-to-32).
//   O : one-hot output, all zeros when E=0
//   D : binary index
//   E : enable
module binaryDecoder #(
    parameter int N = 5
) (
    output logic [2**N-1:0] O,
    input  logic [N-1:0]    D,
    input  logic            E
);

    always_comb begin
        O = '0;
        if (E) begin
            O[D] = 1'b1;
        end
    end

endmodule

// File: rtl/gpr_file.sv
// gpr_file: 2-read / 1-write general-purpose register file, GR0 hardwired
// to zero, asynchronous active-low reset, combinational read ports.
//   clk      : clock, state updates on rising edge
//   rst_n    : asynchronous active-low reset, clears GR1..GR31
//   wr_en    : write enable (decoder enable)
//   wr_addr  : write index
//   wr_data  : write data
//   ra_addr  : read port A index      ra_data : read port A data
//   rb_addr  : read port B index      rb_data : read port B data
//   wr_sel   : decoded one-hot write strobe
// Optional build macro GPR_BYPASS_EN: same-cycle write-through from wr_data
// to the read ports when the read index matches a nonzero write index.
module gpr_file
    import gpr_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic [ADDR_W-1:0]    ra_addr,
    output logic [DATA_W-1:0]    ra_data,
    input  logic [ADDR_W-1:0]    rb_addr,
    output logic [DATA_W-1:0]    rb_data,
    output logic [2**ADDR_W-1:0] wr_sel
);

    localparam int NREG = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(GR0_IDX);

    logic [DATA_W-1:0] regs [NREG];

    binaryDecoder #(.N(ADDR_W)) u_wr_dec (
        .O (wr_sel),
        .D (wr_addr),
        .E (wr_en)
    );

    // Entry 0 is only ever reset, never loaded, so it stays constant zero.
    // Writes are gated purely by the decoded strobe: with wr_en=0 every
    // strobe bit is 0 regardless of unknowns on the address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (wr_sel[i]) begin
                    regs[i] <= wr_data;
                end
            end
        end
    end

`ifdef GPR_BYPASS_EN
    logic byp_live;
    assign byp_live = wr_en && rst_n && (wr_addr != ZERO_IDX);

    always_comb begin
        ra_data = '0;
        rb_data = '0;
        if (ra_addr != ZERO_IDX) begin
            ra_data = (byp_live && ra_addr == wr_addr) ? wr_data : regs[ra_addr];
        end
        if (rb_addr != ZERO_IDX) begin
            rb_data = (byp_live && rb_addr == wr_addr) ? wr_data : regs[rb_addr];
        end
    end
`else
    always_comb begin
        ra_data = '0;
        rb_data = '0;
        if (ra_addr != ZERO_IDX) begin
            ra_data = regs[ra_addr];
        end
        if (rb_addr != ZERO_IDX) begin
            rb_data = regs[rb_addr];
        end
    end
`endif

endmodule

// File: tb/tb_gpr_file.sv
module tb_gpr_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  ra_addr;
    logic [31:0] ra_data;
    logic [4:0]  rb_addr;
    logic [31:0] rb_data;
    logic [31:0] wr_sel;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [32];

    gpr_file dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .ra_addr (ra_addr),
        .ra_data (ra_data),
        .rb_addr (rb_addr),
        .rb_data (rb_data),
        .wr_sel  (wr_sel)
    );

    always #50 clk = ~clk;

    function automatic logic [31:0] exp_sel(input logic en, input logic [4:0] a);
        return en ? (32'h1 << a) : 32'h0;
    endfunction

    // Expected read value: stored contents, write-through when bypass is built in.
    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (rst_n !== 1'b1) return 32'h0;
`ifdef GPR_BYPASS_EN
        if (wr_en && wr_addr == a) return wr_data;
`endif
        return model[a];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    // Advance one rising edge, updating the model from the held inputs.
    task automatic step();
        @(posedge clk);
        if (rst_n && wr_en && wr_addr != 5'd0) model[wr_addr] = wr_data;
        #1;
    endtask

    task automatic drive_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            ra_addr = 5'(i); rb_addr = 5'(31 - i);
            #1;
            checks++;
            if (ra_data !== 32'h0 || rb_data !== 32'h0) begin
                errors++;
                $display("FAIL reset_read idx=%0d ra=%h rb=%h required 0", i, ra_data, rb_data);
            end
        end
        checks++;
        if (wr_sel !== 32'h0) begin
            errors++;
            $display("FAIL reset_wr_sel got %h required 0", wr_sel);
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        #1;
        checks++;
        if (wr_sel !== 32'h0000_0020) begin
            errors++;
            $display("FAIL write5_sel got %h required 00000020", wr_sel);
        end
        step();
        @(negedge clk);
        wr_en = 1'b0; ra_addr = 5'd5;
        #1;
        checks++;
        if (ra_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write5_read got %h required deadbeef", ra_data);
        end
    endtask

    task automatic test_gr0();
        drive_write(5'd0, 32'hFFFFFFFF);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        ra_addr = 5'd0; rb_addr = 5'd0;
        #1;
        checks++;
        if (ra_data !== 32'h0 || rb_data !== 32'h0) begin
            errors++;
            $display("FAIL gr0_read ra=%h rb=%h required 0", ra_data, rb_data);
        end
        step();
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic test_disabled();
        drive_write(5'd21, 32'h0BADF00D);
        @(negedge clk);
        wr_en = 1'b0; wr_addr = 5'd21; wr_data = 32'h12345678; ra_addr = 5'd21;
        #1;
        checks++;
        if (wr_sel !== 32'h0) begin
            errors++;
            $display("FAIL disabled_sel got %h required 0", wr_sel);
        end
        step();
        @(negedge clk);
        wr_addr = 5'bxxxxx; rb_addr = 5'd21;
        step();
        @(negedge clk);
        wr_addr = 5'd0;
        #1;
        checks++;
        if (ra_data !== 32'h0BADF00D || rb_data !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL disabled_hold ra=%h rb=%h required 0badf00d", ra_data, rb_data);
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] pre;
        drive_write(5'd31, 32'h11112222);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'hA5A5A5A5; ra_addr = 5'd31;
        #1;
`ifdef GPR_BYPASS_EN
        pre = 32'hA5A5A5A5;
`else
        pre = 32'h11112222;
`endif
        checks++;
        if (ra_data !== pre) begin
            errors++;
            $display("FAIL same_cycle_pre got %h required %h", ra_data, pre);
        end
        step();
        checks++;
        if (ra_data !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL same_cycle_post got %h required a5a5a5a5", ra_data);
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h1;
        step();
        @(negedge clk);
        wr_addr = 5'd31; wr_data = 32'h2;
        step();
        @(negedge clk);
        wr_en = 1'b0; ra_addr = 5'd10; rb_addr = 5'd31;
        #1;
        checks++;
        if (ra_data !== 32'h1 || rb_data !== 32'h2) begin
            errors++;
            $display("FAIL back_to_back ra=%h rb=%h required 1/2", ra_data, rb_data);
        end
    endtask

    task automatic test_random();
        logic [31:0] ea, eb, es;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            wr_en   = ($urandom_range(0, 3) != 0);
            wr_addr = 5'($urandom_range(0, 31));
            wr_data = $urandom;
            ra_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            rb_addr = ($urandom_range(0, 7) == 0) ? ra_addr : 5'($urandom_range(0, 31));
            #1;
            ea = exp_rd(ra_addr);
            eb = exp_rd(rb_addr);
            es = exp_sel(wr_en, wr_addr);
            checks++;
            if (ra_data !== ea || rb_data !== eb || wr_sel !== es) begin
                errors++;
                $display("FAIL random n=%0d ra[%0d]=%h/%h rb[%0d]=%h/%h sel=%h/%h (got/required)",
                         n, ra_addr, ra_data, ea, rb_addr, rb_data, eb, wr_sel, es);
            end
            step();
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic test_async_reset();
        for (int i = 1; i < 32; i++) drive_write(5'(i), 32'hC0DE0000 | i);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h77777777;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        clear_model();
        #1;
        for (int i = 0; i < 32; i++) begin
            ra_addr = 5'(i); rb_addr = 5'(i ^ 5'h1F);
            #1;
            checks++;
            if (ra_data !== 32'h0 || rb_data !== 32'h0) begin
                errors++;
                $display("FAIL async_reset idx=%0d ra=%h rb=%h required 0", i, ra_data, rb_data);
            end
        end
        step();
        ra_addr = 5'd7;
        #1;
        checks++;
        if (ra_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_blocks_write got %h required 0", ra_data);
        end
        @(negedge clk);
        rst_n = 1'b1; wr_addr = 5'd9; wr_data = 32'h99990001;
        step();
        @(negedge clk);
        wr_en = 1'b0; ra_addr = 5'd9; rb_addr = 5'd7;
        #1;
        checks++;
        if (ra_data !== 32'h99990001 || rb_data !== 32'h0) begin
            errors++;
            $display("FAIL release_write ra=%h rb=%h required 99990001/0", ra_data, rb_data);
        end
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        ra_addr = '0; rb_addr = '0;
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_write_read();
        test_gr0();
        test_disabled();
        test_same_cycle();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
